// File: rtl/hazard_unit.sv
// ID-stage hazard detection: a two-slot destination scoreboard (EX, MEM) drives the
// forwarding codes, load-use / dual-operand stalls, PC hold, flush and a stall counter.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             branch,
   input  logic             cnt_clr,
   output logic             stall1,
   output logic             stall2,
   output logic             is_hazard1,
   output logic [2:0]       hazard_reg1,
   output logic             is_hazard2,
   output logic [2:0]       hazard_reg2,
   output logic             pc_write,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             ex_v_q, ex_v_d, ex_ld_q, ex_ld_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic             mem_v_q, mem_ld_q;
   logic [4:0]       mem_rd_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic ex_prod, mem_prod, rs1_ok, rs2_ok;
   logic m1_ex, m2_ex, m1_mem, m2_mem;
   logic ld_use, dual_ex, dual_mem, stall_any;
   logic [2:0] code1, code2;

   always_comb begin
      ex_prod  = ex_v_q && (ex_rd_q != 5'd0);
      mem_prod = mem_v_q && (mem_rd_q != 5'd0);
      rs1_ok   = id_valid && id_use_rs1 && (id_rs1 != 5'd0);
      rs2_ok   = id_valid && id_use_rs2 && (id_rs2 != 5'd0);

      m1_ex  = rs1_ok && ex_prod && (ex_rd_q == id_rs1);
      m2_ex  = rs2_ok && ex_prod && (ex_rd_q == id_rs2);
      // The newest producer wins, so an EX match masks the MEM channel for that operand.
      m1_mem = rs1_ok && mem_prod && (mem_rd_q == id_rs1) && !m1_ex;
      m2_mem = rs2_ok && mem_prod && (mem_rd_q == id_rs2) && !m2_ex;

      ld_use   = ex_ld_q && (m1_ex || m2_ex);
      dual_ex  = m1_ex && m2_ex && !ex_ld_q;
      dual_mem = m1_mem && m2_mem;

      code1 = 3'd0;
      if (!ld_use && !dual_ex) begin
         if (m1_ex)      code1 = 3'd1;
         else if (m2_ex) code1 = 3'd2;
      end
      code2 = 3'd0;
      if (!dual_mem) begin
         if (m1_mem)      code2 = 3'd3;
         else if (m2_mem) code2 = 3'd4;
      end

      stall1      = ld_use && !branch;
      stall2      = (dual_ex || dual_mem) && !branch;
      hazard_reg1 = branch ? 3'd0 : code1;
      hazard_reg2 = branch ? 3'd0 : code2;
      is_hazard1  = (hazard_reg1 != 3'd0);
      is_hazard2  = (hazard_reg2 != 3'd0);
      stall_any   = stall1 || stall2;
      pc_write    = !stall_any;
      flush       = branch;
      stall_cnt   = cnt_q;
   end

   always_comb begin
      ex_v_d  = id_valid && !id_reg_write && !stall_any && !branch;
      ex_rd_d = id_rd;
      ex_ld_d = id_mem_read;
      cnt_d   = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (stall_any && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_v_q   <= 1'b0;
         ex_rd_q  <= 5'd0;
         ex_ld_q  <= 1'b0;
         mem_v_q  <= 1'b0;
         mem_rd_q <= 5'd0;
         mem_ld_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mem_v_q  <= ex_v_q;
         mem_rd_q <= ex_rd_q;
         mem_ld_q <= ex_ld_q;
         ex_v_q   <= ex_v_d;
         ex_rd_q  <= ex_rd_d;
         ex_ld_q  <= ex_ld_d;
         cnt_q    <= cnt_d;
      end
   end

   // The MEM load flag is kept for symmetry with the EX slot; loads already in MEM forward normally.
   logic unused_mem_ld;
   assign unused_mem_ld = mem_ld_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit with a queue-based scoreboard and a
// list-of-in-flight-instructions reference model.
module tb_hazard_unit;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic id_reg_write = 1'b1, id_mem_read = 1'b0, branch = 1'b0, cnt_clr = 1'b0;
   logic stall1, stall2, is_hazard1, is_hazard2, pc_write, flush;
   logic [2:0] hazard_reg1, hazard_reg2;
   logic [CW-1:0] stall_cnt;

   hazard_unit #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch(branch),
      .cnt_clr(cnt_clr), .stall1(stall1), .stall2(stall2), .is_hazard1(is_hazard1),
      .hazard_reg1(hazard_reg1), .is_hazard2(is_hazard2), .hazard_reg2(hazard_reg2),
      .pc_write(pc_write), .flush(flush), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {bit v; bit [4:0] rd; bit ld;} instr_t;
   typedef struct {int s1; int s2; int ih1; int hr1; int ih2; int hr2; int pcw; int fl; int cnt; int idx;} exp_t;

   instr_t inflight[$];   // index 0 = youngest (EX), 1 = MEM
   exp_t   exp_q[$];
   int     model_cnt = 0;
   int     n_assert = 0, n_fail = 0, n_txn = 0;

   task automatic chk(input string name, input int idx, input int act, input int req);
      n_assert++;
      if (act != req) begin
         n_fail++;
         $display("FAIL txn %0d %s: got %0d expected %0d", idx, name, act, req);
      end
   endtask

   function automatic int find_src(input bit use_it, input bit [4:0] rs);
      if (!id_valid || !use_it || rs == 5'd0) return -1;
      for (int i = 0; i < 2; i++)
         if (inflight[i].v && inflight[i].rd != 5'd0 && inflight[i].rd == rs) return i;
      return -1;
   endfunction

   task automatic model_clear();
      instr_t b;
      b.v = 1'b0; b.rd = 5'd0; b.ld = 1'b0;
      inflight.delete();
      inflight.push_back(b);
      inflight.push_back(b);
      model_cnt = 0;
   endtask

   // One clock of stimulus: drive, predict, push the expectation, advance the model.
   task automatic cycle(input bit rst, input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u1, input bit u2, input bit [4:0] rd, input bit rw,
                        input bit ld, input bit br, input bit clr, output bit stalled);
      exp_t e;
      instr_t n;
      int a, b;
      @(posedge clk); #1;
      reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = ld; branch = br; cnt_clr = clr;
      if (!rst) model_clear();
      a = find_src(u1, rs1);
      b = find_src(u2, rs2);
      e.s1 = 0; e.s2 = 0; e.hr1 = 0; e.hr2 = 0;
      if (!br) begin
         if ((a == 0 || b == 0) && inflight[0].ld) e.s1 = 1;
         else if (a >= 0 && a == b) e.s2 = 1;
         if (e.s1 == 0 && !(a == 0 && b == 0)) e.hr1 = (a == 0) ? 1 : (b == 0) ? 2 : 0;
         if (!(a == 1 && b == 1)) e.hr2 = (a == 1) ? 3 : (b == 1) ? 4 : 0;
      end
      e.ih1 = (e.hr1 != 0); e.ih2 = (e.hr2 != 0);
      e.pcw = !(e.s1 || e.s2); e.fl = br; e.cnt = model_cnt; e.idx = n_txn++;
      exp_q.push_back(e);
      stalled = e.s1 || e.s2;
      if (rst) begin
         n.v = v && !rw && !stalled && !br; n.rd = rd; n.ld = ld;
         inflight.push_front(n);
         void'(inflight.pop_back());
         if (clr) model_cnt = 0;
         else if (stalled && model_cnt < CMAX) model_cnt++;
      end
   endtask

   // Issue one instruction, holding it in ID while the model predicts a stall.
   task automatic issue(input bit v, input bit [4:0] rs1, input bit [4:0] rs2, input bit u1,
                        input bit u2, input bit [4:0] rd, input bit rw, input bit ld,
                        input bit br, input bit clr);
      bit st;
      int k = 0;
      do begin
         cycle(1'b1, v, rs1, rs2, u1, u2, rd, rw, ld, br, clr, st);
         k++;
      end while (st && k < 6);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall1", e.idx, int'(stall1), e.s1);
            chk("stall2", e.idx, int'(stall2), e.s2);
            chk("hazard_reg1", e.idx, int'(hazard_reg1), e.hr1);
            chk("is_hazard1", e.idx, int'(is_hazard1), e.ih1);
            chk("hazard_reg2", e.idx, int'(hazard_reg2), e.hr2);
            chk("is_hazard2", e.idx, int'(is_hazard2), e.ih2);
            chk("pc_write", e.idx, int'(pc_write), e.pcw);
            chk("flush", e.idx, int'(flush), e.fl);
            chk("stall_cnt", e.idx, int'(stall_cnt), e.cnt);
            $display("txn %0d: s1=%0d s2=%0d hr1=%0d hr2=%0d pcw=%0d fl=%0d cnt=%0d",
                     e.idx, stall1, stall2, hazard_reg1, hazard_reg2, pc_write, flush, stall_cnt);
         end
      end
   end

   initial begin : stimulus
      bit st;
      int w;
      model_clear();
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, st);
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, st);
      // addi x5 ; add x6,x5,x7  then with a gap
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      issue(1, 5, 7, 1, 1, 6, 0, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      issue(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      issue(1, 5, 7, 1, 1, 6, 0, 0, 0, 0);
      // lw x5 ; add x6,x7,x5
      issue(1, 0, 0, 1, 0, 5, 0, 1, 0, 0);
      issue(1, 7, 5, 1, 1, 6, 0, 0, 0, 0);
      // addi x5 ; add x6,x5,x5
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      issue(1, 5, 5, 1, 1, 6, 0, 0, 0, 0);
      // addi x5 ; addi x5 ; add x6,x5,x0 ; x0 consumer
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      issue(1, 5, 0, 1, 1, 6, 0, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue(1, 0, 0, 1, 1, 7, 0, 0, 0, 0);
      // addi x5 ; addi x6 ; add x7,x6,x5
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 6, 0, 0, 0, 0);
      issue(1, 6, 5, 1, 1, 7, 0, 0, 0, 0);
      // load-use overridden by branch, then consumer sees the load in MEM
      issue(1, 0, 0, 0, 0, 5, 0, 1, 0, 0);
      issue(1, 7, 5, 1, 1, 6, 0, 0, 1, 0);
      issue(1, 5, 0, 1, 0, 8, 0, 0, 0, 0);
      // reset asserted during a dual-operand stall
      issue(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      cycle(1'b1, 1, 5, 5, 1, 1, 6, 0, 0, 0, 0, st);
      cycle(1'b0, 1, 5, 5, 1, 1, 6, 0, 0, 0, 0, st);
      cycle(1'b1, 1, 5, 5, 1, 1, 6, 0, 0, 0, 0, st);
      // randomized traffic over a small register set to provoke frequent matches
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) cycle(1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, st);
         else
            issue($urandom_range(0, 9) != 0, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      end
      w = 0;
      while (exp_q.size() > 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      n_assert++;
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
